// File: rtl/gpio_input_debounce.sv
`default_nettype none
//============================================================================
// Module : gpio_input_debounce
// Desc   : Per-bit 2-flop synchronizer, counter debouncer, rise/fall pulses
//          and sticky event flags for raw board GPIO inputs. Defining
//          GPIO_DEBOUNCE_IRQ_EN adds irq_mask/irq and a masked interrupt.
// Rev    : 1.0  initial release
//============================================================================
module gpio_input_debounce #(
    parameter int N_INPUTS        = 2,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int CNT_W           = 17
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_INPUTS-1:0] pin_in,
    output logic [N_INPUTS-1:0] level_out,
    output logic [N_INPUTS-1:0] rise_pulse,
    output logic [N_INPUTS-1:0] fall_pulse,
    output logic [N_INPUTS-1:0] event_flags,
    input  logic [N_INPUTS-1:0] event_clr
`ifdef GPIO_DEBOUNCE_IRQ_EN
    ,
    input  logic [N_INPUTS-1:0] irq_mask,
    output logic                irq
`endif
);

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_INPUTS-1:0] r_sync1;
    logic [N_INPUTS-1:0] r_sync2;
    logic [N_INPUTS-1:0] w_diff;
    logic [N_INPUTS-1:0] w_fire;
    logic [N_INPUTS-1:0] w_rise_nxt;
    logic [N_INPUTS-1:0] w_fall_nxt;
    logic [N_INPUTS-1:0] w_flags_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pin_in;
            r_sync2 <= r_sync1;
        end
    end

    // Each bit owns its counter; it saturates at c_last_cnt only for the
    // single cycle in which the level is committed, then restarts at zero.
    for (genvar i = 0; i < N_INPUTS; i++) begin : g_bit
        logic [CNT_W-1:0] r_cnt;

        assign w_diff[i] = r_sync2[i] ^ level_out[i];
        assign w_fire[i] = w_diff[i] && (r_cnt == c_last_cnt);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (!w_diff[i] || w_fire[i]) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign w_rise_nxt  = w_fire & r_sync2;
    assign w_fall_nxt  = w_fire & ~r_sync2;
    // A new event on the same cycle as a clear keeps the flag set.
    assign w_flags_nxt = (event_flags & ~event_clr) | w_rise_nxt | w_fall_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_out   <= '0;
            rise_pulse  <= '0;
            fall_pulse  <= '0;
            event_flags <= '0;
        end else begin
            level_out   <= level_out ^ w_fire;
            rise_pulse  <= w_rise_nxt;
            fall_pulse  <= w_fall_nxt;
            event_flags <= w_flags_nxt;
        end
    end

`ifdef GPIO_DEBOUNCE_IRQ_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |(w_flags_nxt & irq_mask);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gpio_input_debounce.sv
`default_nettype none
//============================================================================
// Module : tb_gpio_input_debounce
// Desc   : Vector-table bench for gpio_input_debounce (N=2, D=4, CNT_W=3).
// Rev    : 1.0  initial release
//============================================================================
module tb_gpio_input_debounce;

    logic       clk;
    logic       rst_n;
    logic [1:0] pin_in;
    logic [1:0] event_clr;
    logic [1:0] level_out;
    logic [1:0] rise_pulse;
    logic [1:0] fall_pulse;
    logic [1:0] event_flags;
`ifdef GPIO_DEBOUNCE_IRQ_EN
    logic [1:0] irq_mask;
    logic       irq;
`endif

    int total;
    int bad;

    // exp packs {level_out, rise_pulse, fall_pulse, event_flags}
    typedef struct {
        logic [1:0] pin;
        logic [1:0] clr;
        logic [1:0] mask;
        logic [7:0] exp;
        logic       irq;
        string      name;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    gpio_input_debounce #(
        .N_INPUTS       (2),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pin_in     (pin_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .event_flags(event_flags),
        .event_clr  (event_clr)
`ifdef GPIO_DEBOUNCE_IRQ_EN
        ,
        .irq_mask   (irq_mask),
        .irq        (irq)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add(input logic [1:0] pin, input logic [1:0] clr,
                                input logic [1:0] mask, input logic [7:0] exp,
                                input logic irq_e, input int n, input string nm);
        for (int i = 0; i < n; i++) vecs.push_back('{pin, clr, mask, exp, irq_e, nm});
    endfunction

    task automatic check_zero(input string nm);
        total++;
        if ({level_out, rise_pulse, fall_pulse, event_flags} !== 8'h00) begin
            bad++;
            $display("FAIL %s: got %b want 00000000", nm,
                     {level_out, rise_pulse, fall_pulse, event_flags});
        end
`ifdef GPIO_DEBOUNCE_IRQ_EN
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL %s irq: got %b want 0", nm, irq);
        end
`endif
    endtask

    task automatic run_vectors(input int first, input int last);
        vec_t e;
        for (int k = first; k < last; k++) begin
            @(negedge clk);
            pin_in    = vecs[k].pin;
            event_clr = vecs[k].clr;
`ifdef GPIO_DEBOUNCE_IRQ_EN
            irq_mask  = vecs[k].mask;
`endif
            exp_q.push_back(vecs[k]);
            @(posedge clk);
            #1;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard vec %0d: got empty queue want entry", k);
            end else begin
                e = exp_q.pop_front();
                if ({level_out, rise_pulse, fall_pulse, event_flags} !== e.exp) begin
                    bad++;
                    $display("FAIL %s vec %0d: got %b want %b", e.name, k,
                             {level_out, rise_pulse, fall_pulse, event_flags}, e.exp);
                end
`ifdef GPIO_DEBOUNCE_IRQ_EN
                total++;
                if (irq !== e.irq) begin
                    bad++;
                    $display("FAIL %s irq vec %0d: got %b want %b", e.name, k, irq, e.irq);
                end
`endif
            end
        end
    endtask

    int n_p1;

    initial begin
        total = 0;
        bad   = 0;

        // Release from reset with both pins already high
        add(2'b11, 2'b00, 2'b00, 8'b00_00_00_00, 1'b0, 5, "rst_rise");
        add(2'b11, 2'b00, 2'b00, 8'b11_11_00_11, 1'b0, 1, "rst_rise");
        add(2'b11, 2'b00, 2'b00, 8'b11_00_00_11, 1'b0, 2, "rst_rise");
        add(2'b11, 2'b11, 2'b00, 8'b11_00_00_00, 1'b0, 1, "clr_both");
        add(2'b11, 2'b00, 2'b00, 8'b11_00_00_00, 1'b0, 1, "clr_both");
        n_p1 = vecs.size();
        // Bounce on bit 0 after a mid-run reset
        add(2'b01, 2'b00, 2'b00, 8'b00_00_00_00, 1'b0, 2, "bounce");
        add(2'b00, 2'b00, 2'b00, 8'b00_00_00_00, 1'b0, 2, "bounce");
        add(2'b01, 2'b00, 2'b00, 8'b00_00_00_00, 1'b0, 2, "bounce");
        add(2'b00, 2'b00, 2'b00, 8'b00_00_00_00, 1'b0, 2, "bounce");
        add(2'b01, 2'b00, 2'b00, 8'b00_00_00_00, 1'b0, 5, "bounce");
        add(2'b01, 2'b00, 2'b00, 8'b01_01_00_01, 1'b0, 1, "bounce_rise");
        add(2'b01, 2'b00, 2'b00, 8'b01_00_00_01, 1'b0, 1, "bounce_rise");
        // Bit 1 glitch lasting 3 synchronized cycles
        add(2'b11, 2'b00, 2'b00, 8'b01_00_00_01, 1'b0, 3, "glitch");
        add(2'b01, 2'b00, 2'b00, 8'b01_00_00_01, 1'b0, 4, "glitch");
        // Fall on bit 0, then clear
        add(2'b01, 2'b01, 2'b00, 8'b01_00_00_00, 1'b0, 1, "pre_clr");
        add(2'b00, 2'b00, 2'b00, 8'b01_00_00_00, 1'b0, 5, "fall");
        add(2'b00, 2'b00, 2'b00, 8'b00_00_01_01, 1'b0, 1, "fall");
        add(2'b00, 2'b00, 2'b00, 8'b00_00_00_01, 1'b0, 1, "fall");
        add(2'b00, 2'b01, 2'b00, 8'b00_00_00_00, 1'b0, 1, "clr0");
        add(2'b00, 2'b00, 2'b00, 8'b00_00_00_00, 1'b0, 1, "clr0");
        // Clear held across a new rise: set wins
        add(2'b01, 2'b01, 2'b00, 8'b00_00_00_00, 1'b0, 5, "set_wins");
        add(2'b01, 2'b01, 2'b00, 8'b01_01_00_01, 1'b0, 1, "set_wins");
        add(2'b01, 2'b00, 2'b00, 8'b01_00_00_01, 1'b0, 2, "set_wins");
        // Independence: simultaneous step, then staggered step
        add(2'b00, 2'b00, 2'b00, 8'b01_00_00_01, 1'b0, 5, "indep_pre");
        add(2'b00, 2'b00, 2'b00, 8'b00_00_01_01, 1'b0, 1, "indep_pre");
        add(2'b00, 2'b11, 2'b00, 8'b00_00_00_00, 1'b0, 1, "indep_pre");
        add(2'b11, 2'b00, 2'b00, 8'b00_00_00_00, 1'b0, 5, "both_rise");
        add(2'b11, 2'b00, 2'b00, 8'b11_11_00_11, 1'b0, 1, "both_rise");
        add(2'b11, 2'b00, 2'b00, 8'b11_00_00_11, 1'b0, 1, "both_rise");
        add(2'b10, 2'b00, 2'b00, 8'b11_00_00_11, 1'b0, 4, "stagger");
        add(2'b00, 2'b00, 2'b00, 8'b11_00_00_11, 1'b0, 1, "stagger");
        add(2'b00, 2'b00, 2'b00, 8'b10_00_01_11, 1'b0, 1, "stagger");
        add(2'b00, 2'b00, 2'b00, 8'b10_00_00_11, 1'b0, 3, "stagger");
        add(2'b00, 2'b00, 2'b00, 8'b00_00_10_11, 1'b0, 1, "stagger");
        add(2'b00, 2'b00, 2'b00, 8'b00_00_00_11, 1'b0, 1, "stagger");
        // Interrupt masking (irq only compared when the feature is built)
        add(2'b00, 2'b11, 2'b10, 8'b00_00_00_00, 1'b0, 1, "irq");
        add(2'b01, 2'b00, 2'b10, 8'b00_00_00_00, 1'b0, 5, "irq_masked");
        add(2'b01, 2'b00, 2'b10, 8'b01_01_00_01, 1'b0, 1, "irq_masked");
        add(2'b01, 2'b00, 2'b10, 8'b01_00_00_01, 1'b0, 1, "irq_masked");
        add(2'b11, 2'b00, 2'b10, 8'b01_00_00_01, 1'b0, 5, "irq_set");
        add(2'b11, 2'b00, 2'b10, 8'b11_10_00_11, 1'b1, 1, "irq_set");
        add(2'b11, 2'b00, 2'b10, 8'b11_00_00_11, 1'b1, 1, "irq_set");
        add(2'b11, 2'b10, 2'b10, 8'b11_00_00_01, 1'b0, 1, "irq_clr");
        add(2'b11, 2'b00, 2'b10, 8'b11_00_00_01, 1'b0, 1, "irq_clr");

        rst_n     = 1'b0;
        pin_in    = 2'b11;
        event_clr = 2'b00;
`ifdef GPIO_DEBOUNCE_IRQ_EN
        irq_mask  = 2'b00;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_hold");
        rst_n = 1'b1;

        run_vectors(0, n_p1);

        // Asynchronous reset mid-operation: outputs drop before any clock edge
        #2;
        pin_in = 2'b00;
        rst_n  = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("rst_held");
        rst_n = 1'b1;

        run_vectors(n_p1, vecs.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
